timing_frame_sched: RTL and testbench

- Scheduler and loader for the timing-event generator's parameter frame: TNO, TOBM, TNC, TNI, TKI, TNP, TKP, CMND.
- Two requesters share the generator: A is the host register path and B is the Ethernet command path. Each fills a private 8-word staging buffer and commits it.
- The block arbitrates commits into a frame queue and presents one frame at a time on stable outputs, with a well-formed RCV strobe.
- It paces normal frames on the generator's slot_free event. Sync, not-sync and reset command frames bypass pacing.

---
 rtl/timing_frame_sched.sv | 182 ++++++++++++++++++
 tb/tb_timing_frame_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/timing_frame_sched.sv
// Parameter-frame scheduler: two staging requesters, commit arbiter,
// frame queue and a slot-paced RCV issue sequencer.
module timing_frame_sched #(
    parameter int QDEPTH    = 4,
    parameter int RCV_SETUP = 8,
    parameter int RCV_WIDTH = 4,
    parameter int RCV_HOLD  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_wr,
    input  logic [2:0]              a_addr,
    input  logic [31:0]             a_data,
    input  logic                    a_commit,
    output logic                    a_busy,
    input  logic                    b_wr,
    input  logic [2:0]              b_addr,
    input  logic [31:0]             b_data,
    input  logic                    b_commit,
    output logic                    b_busy,
    input  logic                    slot_free,
    input  logic                    clr_status,
    output logic [255:0]            frm_o,
    output logic                    RCV,
    output logic [$clog2(QDEPTH):0] q_level,
    output logic                    active,
    output logic                    err_order,
    output logic                    err_ovf,
    output logic                    wr_drop
);
    localparam int AW = $clog2(QDEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [31:0]   a_buf [8];
    logic [31:0]   b_buf [8];
    logic [255:0]  mem [QDEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [255:0]  a_frm, b_frm, g_frm, head;
    logic          prio_b, first_frame, slot_lat;
    logic          full, grant_a, grant_b, gnt;
    logic          enq, rej, pop;

    function automatic logic is_special(input logic [255:0] f);
        return (f[255:224] == 32'h1234FFFF) ||
               (f[255:224] == 32'h9999FFFF) ||
               (f[255:224] == 32'h8888FFFF);
    endfunction

    function automatic logic bad_order(input logic [255:0] f);
        logic [31:0] tni, tki, tnp, tkp;
        tni = f[127:96];
        tki = f[159:128];
        tnp = f[191:160];
        tkp = f[223:192];
        return (tnp != 0 && tkp != 0 && tnp >= tkp) ||
               (tni != 0 && tki != 0 && tni >= tki);
    endfunction

    always_comb begin
        a_frm = '0;
        b_frm = '0;
        for (int i = 0; i < 8; i++) begin
            a_frm[32*i +: 32] = a_buf[i];
            b_frm[32*i +: 32] = b_buf[i];
        end
    end

    // prio_b only moves on contended grants, so the winner of a tie
    // loses the next tie regardless of uncontended grants in between
    assign head    = mem[rd_ptr];
    assign full    = (q_level == (AW+1)'(QDEPTH));
    assign grant_a = a_busy && !full && (!b_busy || !prio_b);
    assign grant_b = b_busy && !full && (!a_busy || prio_b);
    assign gnt     = grant_a || grant_b;
    assign g_frm   = grant_a ? a_frm : b_frm;
    assign enq     = gnt && (is_special(g_frm) || !bad_order(g_frm));
    assign rej     = gnt && !enq;
    assign pop     = (state == IDLE) && (q_level != 0) &&
                     (first_frame || slot_lat || is_special(head));
    assign active  = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (pop) state_n = SETUP;
            end
            SETUP: begin
                cnt_n = cnt + 16'd1;
                if (cnt == 16'(RCV_SETUP - 1)) begin
                    state_n = STROBE;
                    cnt_n   = '0;
                end
            end
            STROBE: begin
                cnt_n = cnt + 16'd1;
                if (cnt == 16'(RCV_WIDTH - 1)) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end
            end
            HOLD: begin
                cnt_n = cnt + 16'd1;
                if (cnt == 16'(RCV_HOLD - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            RCV         <= 1'b0;
            frm_o       <= '1;
            first_frame <= 1'b1;
            slot_lat    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            RCV      <= (state_n == STROBE);
            slot_lat <= slot_free || (slot_lat && !pop);
            if (pop) begin
                frm_o       <= head;
                first_frame <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= g_frm;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_level <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            q_level <= q_level + (AW+1)'(enq) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_busy    <= 1'b0;
            b_busy    <= 1'b0;
            prio_b    <= 1'b0;
            err_order <= 1'b0;
            err_ovf   <= 1'b0;
            wr_drop   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                a_buf[i] <= '1;
                b_buf[i] <= '1;
            end
        end else begin
            if (a_wr && !a_busy) a_buf[a_addr] <= a_data;
            if (b_wr && !b_busy) b_buf[b_addr] <= b_data;
            if (a_commit && !a_busy) a_busy <= 1'b1;
            else if (grant_a)        a_busy <= 1'b0;
            if (b_commit && !b_busy) b_busy <= 1'b1;
            else if (grant_b)        b_busy <= 1'b0;
            if (a_busy && b_busy && gnt) prio_b <= grant_a;
            err_order <= rej;
            err_ovf   <= (full && (a_busy || b_busy)) ||
                         (err_ovf && !clr_status);
            wr_drop   <= (a_busy && (a_wr || a_commit)) ||
                         (b_busy && (b_wr || b_commit)) ||
                         (wr_drop && !clr_status);
        end
    end
endmodule

// File: tb/tb_timing_frame_sched.sv
// Directed bench for timing_frame_sched: staging, arbitration,
// validation, overflow, slot pacing, special bypass and reset.
module tb_timing_frame_sched;
    typedef logic [255:0] w_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_wr = 1'b0, b_wr = 1'b0;
    logic [2:0]   a_addr = '0, b_addr = '0;
    logic [31:0]  a_data = '0, b_data = '0;
    logic         a_commit = 1'b0, b_commit = 1'b0;
    logic         a_busy, b_busy;
    logic         slot_free = 1'b0, clr_status = 1'b0;
    logic [255:0] frm_o;
    logic         RCV;
    logic [2:0]   q_level;
    logic         active, err_order, err_ovf, wr_drop;

    int n_cmp = 0;
    int n_err = 0;

    w_t ones, f1, f2, fa, fb, fr, f5, fn, fs;

    always #5 clk = ~clk;

    timing_frame_sched dut (
        .clk(clk), .rst(rst),
        .a_wr(a_wr), .a_addr(a_addr), .a_data(a_data),
        .a_commit(a_commit), .a_busy(a_busy),
        .b_wr(b_wr), .b_addr(b_addr), .b_data(b_data),
        .b_commit(b_commit), .b_busy(b_busy),
        .slot_free(slot_free), .clr_status(clr_status),
        .frm_o(frm_o), .RCV(RCV), .q_level(q_level),
        .active(active), .err_order(err_order),
        .err_ovf(err_ovf), .wr_drop(wr_drop)
    );

    task automatic chk(input string tag, input w_t got, input w_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic w_t mkf(
        input logic [31:0] tno, tobm, tnc, tni,
        input logic [31:0] tki, tnp, tkp, cmnd);
        return {cmnd, tkp, tnp, tki, tni, tnc, tobm, tno};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_rst();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic r, input w_t f, input logic go);
        for (int i = 0; i < 8; i++) begin
            if (!r) begin
                a_wr = 1'b1; a_addr = 3'(i); a_data = f[32*i +: 32];
            end else begin
                b_wr = 1'b1; b_addr = 3'(i); b_data = f[32*i +: 32];
            end
            tick();
        end
        a_wr = 1'b0;
        b_wr = 1'b0;
        if (go) begin
            if (!r) a_commit = 1'b1;
            else    b_commit = 1'b1;
            tick();
            a_commit = 1'b0;
            b_commit = 1'b0;
        end
    endtask

    task automatic pulse_slot();
        slot_free = 1'b1;
        tick();
        slot_free = 1'b0;
        tick();
    endtask

    // entered on the first negedge after a pop
    task automatic check_issue(input string tag);
        repeat (7) tick();
        chk({tag, ".rcv_pre"}, w_t'(RCV), w_t'(0));
        tick();
        chk({tag, ".rcv_rise"}, w_t'(RCV), w_t'(1));
        repeat (3) tick();
        chk({tag, ".rcv_hi"}, w_t'(RCV), w_t'(1));
        tick();
        chk({tag, ".rcv_fall"}, w_t'(RCV), w_t'(0));
        repeat (7) tick();
        chk({tag, ".act_hold"}, w_t'(active), w_t'(1));
        tick();
        chk({tag, ".act_end"}, w_t'(active), w_t'(0));
    endtask

    initial begin
        ones = '1;
        f1 = mkf(32'h10, 32'h20, 32'h30, 32'd5, 32'd9, 32'd0, 32'd0, 32'h0);
        f2 = mkf(32'h11, 32'h21, 32'h31, 32'd1, 32'd2, 32'd3, 32'd4, 32'h0);
        fa = mkf(32'hA1, 32'hA2, 32'hA3, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0);
        fb = mkf(32'hB1, 32'hB2, 32'hB3, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0);
        fr = mkf(32'h1, 32'h2, 32'h3, 32'd9, 32'd5, 32'd0, 32'd0, 32'h0);
        f5 = mkf(32'h55, 32'h5, 32'h5, 32'd1, 32'd3, 32'd0, 32'd0, 32'h0);
        fn = mkf(32'h50, 32'h51, 32'h52, 32'd0, 32'd0, 32'd2, 32'd8, 32'h0);
        fs = mkf(32'h60, 32'h61, 32'h62, 32'd9, 32'd1, 32'd0, 32'd0,
                 32'h8888FFFF);

        do_rst();
        chk("rst.frm", frm_o, ones);
        chk("rst.rcv", w_t'(RCV), w_t'(0));
        chk("rst.qlvl", w_t'(q_level), w_t'(0));
        chk("rst.abusy", w_t'(a_busy), w_t'(0));
        chk("rst.bbusy", w_t'(b_busy), w_t'(0));
        chk("rst.active", w_t'(active), w_t'(0));
        chk("rst.eord", w_t'(err_order), w_t'(0));
        chk("rst.eovf", w_t'(err_ovf), w_t'(0));
        chk("rst.wdrop", w_t'(wr_drop), w_t'(0));

        load(1'b0, f1, 1'b1);
        chk("t1.busy", w_t'(a_busy), w_t'(1));
        chk("t1.q0", w_t'(q_level), w_t'(0));
        tick();
        chk("t1.q1", w_t'(q_level), w_t'(1));
        chk("t1.busy_clr", w_t'(a_busy), w_t'(0));
        tick();
        chk("t1.q_pop", w_t'(q_level), w_t'(0));
        chk("t1.frm", frm_o, f1);
        chk("t1.active", w_t'(active), w_t'(1));
        check_issue("t1");

        load(1'b1, f2, 1'b1);
        tick();
        repeat (10) tick();
        chk("t2.wait_q", w_t'(q_level), w_t'(1));
        chk("t2.wait_act", w_t'(active), w_t'(0));
        chk("t2.frm_keep", frm_o, f1);
        pulse_slot();
        chk("t2.q_pop", w_t'(q_level), w_t'(0));
        chk("t2.frm", frm_o, f2);
        check_issue("t2");

        do_rst();
        load(1'b0, fa, 1'b0);
        load(1'b1, fb, 1'b0);
        a_commit = 1'b1;
        b_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        b_commit = 1'b0;
        chk("t3.both_a", w_t'(a_busy), w_t'(1));
        chk("t3.both_b", w_t'(b_busy), w_t'(1));
        tick();
        chk("t3.g1_a", w_t'(a_busy), w_t'(0));
        chk("t3.g1_b", w_t'(b_busy), w_t'(1));
        tick();
        chk("t3.g2_b", w_t'(b_busy), w_t'(0));
        chk("t3.g2_q", w_t'(q_level), w_t'(1));
        chk("t3.frm", frm_o, fa);
        a_commit = 1'b1;
        b_commit = 1'b1;
        tick();
        a_commit = 1'b0;
        b_commit = 1'b0;
        tick();
        chk("t3.r_a", w_t'(a_busy), w_t'(1));
        chk("t3.r_b", w_t'(b_busy), w_t'(0));
        tick();
        chk("t3.r_a2", w_t'(a_busy), w_t'(0));
        chk("t3.r_q", w_t'(q_level), w_t'(3));

        do_rst();
        load(1'b0, fr, 1'b1);
        chk("t4.busy", w_t'(a_busy), w_t'(1));
        tick();
        chk("t4.eord", w_t'(err_order), w_t'(1));
        chk("t4.q", w_t'(q_level), w_t'(0));
        chk("t4.busy_clr", w_t'(a_busy), w_t'(0));
        tick();
        chk("t4.eord_end", w_t'(err_order), w_t'(0));
        chk("t4.active", w_t'(active), w_t'(0));

        do_rst();
        load(1'b0, f1, 1'b1);
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            load(1'b0, mkf(32'h40 + k, 32'h1, 32'h2, 32'd1, 32'd2,
                           32'd3, 32'd4, 32'h0), 1'b1);
            tick();
        end
        chk("t5.full", w_t'(q_level), w_t'(4));
        load(1'b1, f5, 1'b1);
        tick();
        chk("t5.eovf", w_t'(err_ovf), w_t'(1));
        chk("t5.bbusy", w_t'(b_busy), w_t'(1));
        chk("t5.q", w_t'(q_level), w_t'(4));
        b_wr = 1'b1;
        b_addr = 3'd0;
        b_data = 32'hDEADBEEF;
        tick();
        b_wr = 1'b0;
        chk("t5.wdrop", w_t'(wr_drop), w_t'(1));
        pulse_slot();
        chk("t5.pop_q", w_t'(q_level), w_t'(3));
        chk("t5.still_busy", w_t'(b_busy), w_t'(1));
        tick();
        chk("t5.enq_q", w_t'(q_level), w_t'(4));
        chk("t5.busy_clr", w_t'(b_busy), w_t'(0));
        chk("t5.eovf_sticky", w_t'(err_ovf), w_t'(1));
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("t5.eovf_clr", w_t'(err_ovf), w_t'(0));
        chk("t5.wdrop_clr", w_t'(wr_drop), w_t'(0));

        do_rst();
        load(1'b0, f1, 1'b1);
        repeat (2) tick();
        check_issue("t6a");
        load(1'b0, fn, 1'b1);
        tick();
        load(1'b0, fs, 1'b1);
        tick();
        chk("t6.q2", w_t'(q_level), w_t'(2));
        repeat (5) tick();
        chk("t6.wait_q", w_t'(q_level), w_t'(2));
        chk("t6.wait_act", w_t'(active), w_t'(0));
        pulse_slot();
        chk("t6.frm_n", frm_o, fn);
        chk("t6.q1", w_t'(q_level), w_t'(1));
        check_issue("t6n");
        tick();
        chk("t6.frm_s", frm_o, fs);
        chk("t6.q0", w_t'(q_level), w_t'(0));
        chk("t6.act_s", w_t'(active), w_t'(1));
        repeat (8) tick();
        chk("t6.strobe", w_t'(RCV), w_t'(1));
        rst = 1'b1;
        tick();
        chk("t6.rst_rcv", w_t'(RCV), w_t'(0));
        chk("t6.rst_frm", frm_o, ones);
        chk("t6.rst_act", w_t'(active), w_t'(0));
        chk("t6.rst_q", w_t'(q_level), w_t'(0));
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
